// File: rtl/cla_add_sched_if.sv
// -----------------------------------------------------------------------------
// cla_add_sched_if
// Bundle for the two requester channels and the single response channel of
// cla_add_sched.
//
// Handshake semantics, which apply to every channel in this bundle:
//   A transfer happens on a rising clock edge where valid and ready are both
//   high. The source holds valid and its payload stable until that edge.
//   Ready may depend combinationally on valid. Valid never depends on ready.
//
// Signals (W = 4*NIBBLES):
//   req0_valid/req0_ready, req0_a[W], req0_b[W], req0_sub : requester 0
//   req1_valid/req1_ready, req1_a[W], req1_b[W], req1_sub : requester 1
//   rsp_valid/rsp_ready, rsp_id, rsp_sum[W], rsp_cout, rsp_ovf : response
// Modports:
//   master - requesters and response consumer (drives valid/operands/rsp_ready)
//   slave  - the scheduler/adder (drives req ready and the response)
// -----------------------------------------------------------------------------
interface cla_add_sched_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_sub;

    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_sub;

    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_sum;
    logic         rsp_cout;
    logic         rsp_ovf;

    modport master (
        output req0_valid, req0_a, req0_b, req0_sub,
        output req1_valid, req1_a, req1_b, req1_sub,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sub,
        input  req1_valid, req1_a, req1_b, req1_sub,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
    );
endinterface

// File: rtl/cla_add_sched.sv
// -----------------------------------------------------------------------------
// cla_add_sched
// Two-requester add/subtract unit built around a single 4-bit carry-lookahead
// slice that is reused serially, one nibble per cycle, from LSB to MSB.
// Requesters are served round-robin, one operation at a time.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset
//   bus      - cla_add_sched_if.slave (two request channels + response channel)
//   o_state  - current FSM state (IDLE=0, CALC=1, DONE=2) for observation
//
// Operation: accept on edge T -> NIBBLES CALC cycles -> DONE; rsp_valid is a
// registered flag that rises one edge after entering DONE, i.e. at T+NIBBLES+1,
// and stays high until the response handshake returns the FSM to IDLE.
// -----------------------------------------------------------------------------
module cla_add_sched #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    cla_add_sched_if.slave       bus,
    output logic [1:0]           o_state
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;         // already inverted for subtract
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic             r_id;
    logic [W-1:0]     r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_last;      // requester granted most recently
    logic             r_rsp_valid;

    logic             w_accept;
    logic             w_gid;
    logic             w_last_nib;

    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [3:0]       w_g;
    logic [3:0]       w_p;
    logic [4:0]       w_c;
    logic [3:0]       w_s;

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and grant. Ready is gated with rst so that no requester sees
    // ready while reset is held, even though the state already reads IDLE.
    // On a tie the requester not granted last wins.
    // ------------------------------------------------------------------------
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_gid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!rst && (bus.req0_valid || bus.req1_valid)) begin
                    w_accept = 1'b1;
                    w_gid    = (bus.req0_valid && bus.req1_valid) ? ~r_last
                                                                  : bus.req1_valid;
                    w_next   = S_CALC;
                end
            end
            S_CALC: begin
                if (w_last_nib) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (r_rsp_valid && bus.rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign w_last_nib     = (r_idx == LAST_IDX);
    assign bus.req0_ready = w_accept & ~w_gid;
    assign bus.req1_ready = w_accept & w_gid;

    // ------------------------------------------------------------------------
    // Nibble selection for the current slice position
    // ------------------------------------------------------------------------
    always_comb begin
        w_a_nib = 4'd0;
        w_b_nib = 4'd0;
        for (int n = 0; n < NIBBLES; n++) begin
            if (r_idx == IDX_W'(n)) begin
                w_a_nib = r_a[n*4 +: 4];
                w_b_nib = r_b[n*4 +: 4];
            end
        end
    end

    // ------------------------------------------------------------------------
    // The one 4-bit carry-lookahead slice: every carry is expanded directly
    // from generate/propagate and the registered carry-in.
    // ------------------------------------------------------------------------
    assign w_g    = w_a_nib & w_b_nib;
    assign w_p    = w_a_nib ^ w_b_nib;
    assign w_c[0] = r_carry;
    assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_s    = w_p ^ w_c[3:0];

    // ------------------------------------------------------------------------
    // Datapath registers. Subtract is A + ~B + 1: the +1 enters as the initial
    // carry. The carry register is reloaded on every accept, so the carry out
    // of one operation never leaks into the next.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_id        <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_last      <= 1'b1;
            r_rsp_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a     <= w_gid ? bus.req1_a : bus.req0_a;
                r_b     <= w_gid ? (bus.req1_sub ? ~bus.req1_b : bus.req1_b)
                                 : (bus.req0_sub ? ~bus.req0_b : bus.req0_b);
                r_carry <= w_gid ? bus.req1_sub : bus.req0_sub;
                r_idx   <= '0;
                r_id    <= w_gid;
                r_last  <= w_gid;
            end

            if (r_state == S_CALC) begin
                for (int n = 0; n < NIBBLES; n++) begin
                    if (r_idx == IDX_W'(n)) begin
                        r_sum[n*4 +: 4] <= w_s;
                    end
                end
                r_carry <= w_c[4];
                if (w_last_nib) begin
                    r_idx  <= '0;
                    r_cout <= w_c[4];
                    // carry into the sign bit differs from carry out of it
                    r_ovf  <= w_c[3] ^ w_c[4];
                end else begin
                    r_idx  <= r_idx + 1'b1;
                end
            end

            if (r_state == S_DONE) begin
                if (!r_rsp_valid) begin
                    r_rsp_valid <= 1'b1;
                end else if (bus.rsp_ready) begin
                    r_rsp_valid <= 1'b0;
                end
            end
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_id;
    assign bus.rsp_sum   = r_sum;
    assign bus.rsp_cout  = r_cout;
    assign bus.rsp_ovf   = r_ovf;
    assign o_state       = r_state;

endmodule

// File: doc/cla_add_sched.md
CLA_ADD_SCHED -- requirements
Module: cla_add_sched

Interface
REQ-001 Parameter NIBBLES, default 4, number of 4-bit slices per operation; operand width W = 4*NIBBLES.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-high.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_a, req0_b  input  W each  requester 0 operands.
REQ-007 req0_sub  input  1  requester 0 operation: 0 = A+B, 1 = A-B.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_sub  same as REQ-004..007, requester 1.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts result.
REQ-011 rsp_id  output  1  index of requester that owns the result.
REQ-012 rsp_sum  output  W  result.
REQ-013 rsp_cout  output  1  carry out of MSB (subtract: 1 = no borrow).
REQ-014 rsp_ovf  output  1  two's-complement signed overflow.

Function
REQ-015 The block SHALL contain exactly one 4-bit carry-lookahead adder slice (g = a&b, p = a^b, full lookahead carries), shared by both requesters and reused serially across nibbles.
REQ-016 FSM states SHALL be IDLE, CALC, DONE.
REQ-017 IDLE: if any reqN_valid is high, grant one requester; reqN_ready SHALL be high combinationally for the granted requester only, low otherwise; transition to CALC on that edge.
REQ-018 Arbitration SHALL be round-robin: if both valid, grant the requester not granted last; pointer updates on every accept; after reset requester 0 wins a tie.
REQ-019 On accept: latch A, B' = sub ? ~B : B, carry register = sub, nibble index = 0, owner id.
REQ-020 CALC: each cycle the slice SHALL add nibble[idx] of A and B' with the carry register; store sum nibble, register carry out, idx increments; after idx = NIBBLES-1 transition to DONE.
REQ-021 rsp_ovf SHALL equal carry into bit W-1 XOR carry out of bit W-1, captured on the final nibble.
REQ-022 Latency: accept on edge T -> rsp_valid high from edge T+NIBBLES+1 (T+5 at default).
REQ-023 DONE: rsp_valid high, rsp_* stable until rsp_valid & rsp_ready; on that edge return to IDLE.
REQ-024 Both reqN_ready SHALL be low in CALC and DONE; requesters hold valid and operands until ready.
REQ-025 Next accept SHALL occur no earlier than the cycle after the response handshake (IDLE occupies at least one cycle).
REQ-026 reqN_valid deasserting while not granted SHALL be ignored without error; operands are sampled only at accept.
REQ-027 Carry and nibble index SHALL wrap cleanly: idx never exceeds NIBBLES-1; carry out of final nibble is not fed into a later operation.

Reset
REQ-028 rst high SHALL immediately force state IDLE, rsp_valid 0, req0_ready 0, req1_ready 0, rsp_sum 0, rsp_cout 0, rsp_ovf 0, rsp_id 0, idx 0, carry 0, round-robin pointer = requester 1 last.
REQ-029 Reset asserted mid-CALC or DONE SHALL discard the operation; no response is produced for it after reset release.
REQ-030 First accept SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-031 req0 add 0x1234 + 0x0FFF -> rsp_sum 0x2233, cout 0, ovf 0, id 0, rsp_valid exactly 5 cycles after accept.
REQ-032 req1 add 0xFFFF + 0x0001 -> sum 0x0000, cout 1, ovf 0; add 0x7FFF + 0x0001 -> sum 0x8000, cout 0, ovf 1.
REQ-033 req0 sub 0x0005 - 0x0007 -> sum 0xFFFE, cout 0, ovf 0; sub 0x8000 - 0x0001 -> sum 0x7FFF, cout 1, ovf 1.
REQ-034 Both valid continuously, 4 ops each -> grants alternate 0,1,0,1,...; rsp_id matches; no op lost or duplicated.
REQ-035 rsp_ready held low 3 cycles in DONE -> rsp_* stable, both ready low, single handshake on 4th cycle.
REQ-036 rst pulsed at 2nd CALC cycle -> all outputs at reset values, no rsp_valid until a new request is accepted.
